// File: rtl/in_pass_pkg.sv
// Shared definitions for the input-pass BEL: channel mode encodings and the
// width helper for the debounce counter.
package in_pass_pkg;

    localparam logic [1:0] MODE_COMB = 2'b00;
    localparam logic [1:0] MODE_REG  = 2'b01;
    localparam logic [1:0] MODE_SYNC = 2'b10;
    localparam logic [1:0] MODE_FILT = 2'b11;

    // Counter must hold 0..filterCycles; clamp so a degenerate setting still yields a 1-bit counter.
    function automatic int cntWidth(input int filterCycles);
        return (filterCycles < 1) ? 1 : $clog2(filterCycles + 1);
    endfunction

endpackage

// File: rtl/cus_mux41.sv
// Behavioural stand-in for the tile library 4:1 mux cell (S1 selects the upper pair).
module cus_mux41 (
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic S0,
    input  logic S1,
    output logic X
);

    assign X = S1 ? (S0 ? A3 : A2) : (S0 ? A1 : A0);

endmodule

// File: rtl/in_pass_channel.sv
// One input-pass channel: comb / registered / 2-flop sync / sync+debounce, picked by mode.
// Optional rising-edge pulse output when INPASS_RISE_PULSE_EN is defined.
module in_pass_channel
    import in_pass_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic       UserCLK,
    input  logic       RESET,
    input  logic       I,
    input  logic [1:0] mode,
`ifdef INPASS_RISE_PULSE_EN
    output logic       O_rise,
`endif
    output logic       O
);

    localparam int              CntW    = cntWidth(FILTER_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic            r1;
    logic            s1;
    logic            s2;
    logic            filt;
    logic [CntW-1:0] cnt;

    // Every flop runs in every mode, so switching mode never needs a warm-up period.
    // NOTE: sequential state uses non-blocking assignments so s1 -> s2 forms a real two-stage chain.
    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            r1   <= 1'b0;
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            r1 <= I;
            s1 <= I;
            s2 <= s1;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CntLast) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CntOne;
            end
        end
    end

    cus_mux41 u_outMux (
        .A0 (I),
        .A1 (r1),
        .A2 (s2),
        .A3 (filt),
        .S0 (mode[0]),
        .S1 (mode[1]),
        .X  (O)
    );

`ifdef INPASS_RISE_PULSE_EN
    logic selReg;
    logic prev;

    // COMB mode has no registered value of its own, so the pulse tracks the synchroniser.
    cus_mux41 u_riseMux (
        .A0 (s2),
        .A1 (r1),
        .A2 (s2),
        .A3 (filt),
        .S0 (mode[0]),
        .S1 (mode[1]),
        .X  (selReg)
    );

    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) prev <= 1'b0;
        else       prev <= selReg;
    end

    assign O_rise = selReg & ~prev;
`endif

endmodule

// File: rtl/in_pass_cfg_filter.sv
// Input-pass BEL top: NUM_CH independent channels, each configured by two frame bits.
// Define INPASS_RISE_PULSE_EN to add the per-channel O_rise pulse outputs.
module in_pass_cfg_filter #(
    parameter  int NUM_CH        = 4,
    parameter  int FILTER_CYCLES = 4,
    localparam int NoConfigBits  = 2 * NUM_CH
) (
    input  logic                    UserCLK,
    input  logic                    RESET,
    input  logic [NUM_CH-1:0]       I,
    output logic [NUM_CH-1:0]       O,
`ifdef INPASS_RISE_PULSE_EN
    output logic [NUM_CH-1:0]       O_rise,
`endif
    input  logic [NoConfigBits-1:0] ConfigBits
);

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        in_pass_channel #(
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_ch (
            .UserCLK (UserCLK),
            .RESET   (RESET),
            .I       (I[c]),
            .mode    (ConfigBits[2*c +: 2]),
`ifdef INPASS_RISE_PULSE_EN
            .O_rise  (O_rise[c]),
`endif
            .O       (O[c])
        );
    end

endmodule
